// File: rtl/pulse_shift_in.sv
// Down-counting strobe generator driving a right-shifting SIPO register.
// Counts captured bits since the last restart.
module pulse_shift_in #(
  parameter int unsigned CounterWidth   = 8,
  parameter int unsigned InitialDivisor = 255,
  parameter int unsigned ShiftWidth     = 8,
  parameter logic        ResetValue     = 1'b1,
  localparam int unsigned CntW = $clog2(ShiftWidth + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    restart,
  input  logic [CounterWidth-1:0] divisor,
  input  logic                    enable,
  input  logic                    serial_in,
  output logic                    pulse_out,
  output logic [ShiftWidth-1:0]   parallel_out,
  output logic                    serial_out,
  output logic [CntW-1:0]         bit_count,
  output logic                    full
);

  localparam logic [CntW-1:0] CntMax = CntW'(ShiftWidth);

  logic [CounterWidth-1:0] counter;
  logic                    cnt_zero;

  assign cnt_zero   = (counter == '0);
  assign pulse_out  = enable & ~restart
                    & ~rst & cnt_zero;
  assign serial_out = parallel_out[0];
  assign full       = (bit_count == CntMax);

  // Down-counter: restart reloads, expiry reloads, else decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= CounterWidth'(InitialDivisor);
    end else if (restart) begin
      counter <= divisor;
    end else if (enable) begin
      if (cnt_zero) counter <= divisor;
      else          counter <= counter - 1'b1;
    end
  end

  // Shift register: new bit enters at the MSB on each strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parallel_out <= {ShiftWidth{ResetValue}};
    end else if (pulse_out) begin
      parallel_out <= {serial_in,
                       parallel_out[ShiftWidth-1:1]};
    end
  end

  // Captured-bit count, saturating once the register is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_count <= '0;
    end else if (restart) begin
      bit_count <= '0;
    end else if (pulse_out && !full) begin
      bit_count <= bit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pulse_shift_in.sv
// Directed bench for pulse_shift_in.
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_pulse_shift_in;

  logic       clk = 1'b0;
  logic       rst;
  logic       restart;
  logic [7:0] divisor;
  logic       enable;
  logic       serial_in;
  logic       pulse_out;
  logic [7:0] parallel_out;
  logic       serial_out;
  logic [3:0] bit_count;
  logic       full;

  int total  = 0;
  int passed = 0;
  int n;
  logic [7:0] snap;
  logic [7:0] seq;

  pulse_shift_in dut (
    .clk          (clk),
    .rst          (rst),
    .restart      (restart),
    .divisor      (divisor),
    .enable       (enable),
    .serial_in    (serial_in),
    .pulse_out    (pulse_out),
    .parallel_out (parallel_out),
    .serial_out   (serial_out),
    .bit_count    (bit_count),
    .full         (full)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  // Returns the 1-based cycle index of the next
  // pulse (0 on timeout); leaves time in the
  // pulse cycle, just after the falling edge.
  task automatic to_pulse(
    input  int max,
    output int cyc
  );
    cyc = 0;
    for (int i = 1; i <= max; i++) begin
      #1;
      if (pulse_out) begin
        cyc = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst       = 1'b1;
    restart   = 1'b0;
    divisor   = 8'd3;
    enable    = 1'b0;
    serial_in = 1'b0;
    #2;
    chk("rst_par",   parallel_out, 8'hFF);
    chk("rst_cnt",   bit_count, 0);
    chk("rst_pulse", pulse_out, 0);
    chk("rst_full",  full, 0);
    chk("rst_sout",  serial_out, 1);

    // Free-run from the reset load of 255.
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b1;
    to_pulse(300, n);
    chk("first_pulse", n, 256);
    @(negedge clk);
    to_pulse(10, n);
    chk("period_a", n, 4);
    @(negedge clk);
    to_pulse(10, n);
    chk("period_b", n, 4);

    // Half-bit alignment.
    @(negedge clk);
    restart = 1'b1;
    divisor = 8'd4;
    #1;
    chk("restart_nopulse", pulse_out, 0);
    @(negedge clk);
    restart = 1'b0;
    divisor = 8'd7;
    to_pulse(20, n);
    chk("half_bit", n, 5);
    @(negedge clk);
    to_pulse(20, n);
    chk("full_bit_a", n, 8);
    @(negedge clk);
    to_pulse(20, n);
    chk("full_bit_b", n, 8);
    @(negedge clk);
    chk("count_3", bit_count, 3);

    // Capture with a strobe every cycle.
    restart = 1'b1;
    divisor = 8'd0;
    @(negedge clk);
    restart = 1'b0;
    seq = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      serial_in = seq[i];
      #1;
      chk("cap_pulse", pulse_out, 1);
      if (i == 7) begin
        chk("cap_cnt7", bit_count, 7);
        chk("cap_nfull", full, 0);
      end
      @(negedge clk);
    end
    chk("cap_par",  parallel_out, 8'h4D);
    chk("cap_full", full, 1);
    chk("cap_cnt",  bit_count, 8);
    chk("cap_sout", serial_out, 1);
    serial_in = 1'b1;
    @(negedge clk);
    chk("ninth_par", parallel_out, 8'hA6);
    chk("ninth_cnt", bit_count, 8);

    // Enable gating delays the strobe.
    restart = 1'b1;
    divisor = 8'd5;
    @(negedge clk);
    restart = 1'b0;
    serial_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    snap = parallel_out;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("gate_nopulse", pulse_out, 0);
      @(negedge clk);
    end
    chk("gate_hold", parallel_out, snap);
    enable = 1'b1;
    to_pulse(20, n);
    chk("gate_delay", n, 4);
    @(negedge clk);
    chk("gate_cnt", bit_count, 1);

    // Restart wins over an expiring counter.
    restart = 1'b1;
    divisor = 8'd0;
    @(negedge clk);
    restart = 1'b0;
    divisor = 8'd2;
    #1;
    chk("pri_pre_pulse", pulse_out, 1);
    @(negedge clk);
    chk("pri_pre_cnt", bit_count, 1);
    @(negedge clk);
    @(negedge clk);
    restart   = 1'b1;
    serial_in = ~parallel_out[7];
    snap      = parallel_out;
    #1;
    chk("pri_nopulse", pulse_out, 0);
    @(negedge clk);
    restart = 1'b0;
    chk("pri_noshift", parallel_out, snap);
    chk("pri_cnt", bit_count, 0);
    to_pulse(10, n);
    chk("pri_reload", n, 3);
    @(negedge clk);

    // Async reset mid-capture.
    restart   = 1'b1;
    divisor   = 8'd0;
    serial_in = 1'b0;
    @(negedge clk);
    restart = 1'b0;
    repeat (5) @(negedge clk);
    chk("ar_cnt5", bit_count, 5);
    chk("ar_top0", parallel_out[7:3], 0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_par",   parallel_out, 8'hFF);
    chk("ar_cnt",   bit_count, 0);
    chk("ar_pulse", pulse_out, 0);
    chk("ar_full",  full, 0);
    @(negedge clk);
    rst     = 1'b0;
    divisor = 8'd3;
    to_pulse(300, n);
    chk("ar_initdiv", n, 256);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pulse_shift_in.md
Name: pulse_shift_in

Overview:
- Combined timing and capture block for serial receivers: a programmable down-counting pulse generator whose pulses strobe a right-shifting serial-in/parallel-out register.
- Used by UART-style receivers:
  - restart with a half-period divisor to align to mid-bit;
  - then run with a full-period divisor, sampling one serial bit per pulse;
  - the first received bit ends up at the LSB.
- Also reports how many bits have been captured since the last restart.

Parameters:
- CounterWidth, 8, width of the divisor input and the internal down-counter.
- InitialDivisor, 255, counter value loaded by asynchronous reset; must fit in CounterWidth bits.
- ShiftWidth, 8, number of bits in the shift register (at least 2).
- ResetValue, 1'b1, single-bit value replicated into every shift-register bit on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- restart  input  1  synchronous reload: counter takes divisor, bit count clears, no pulse that cycle.
- divisor  input  CounterWidth  reload value; pulse period is divisor+1 enabled cycles.
- enable  input  1  counter runs only when high.
- serial_in  input  1  serial data sampled on each pulse.
- pulse_out  output  1  one-cycle strobe when the counter expires.
- parallel_out  output  ShiftWidth  shift register contents.
- serial_out  output  1  current parallel_out[0].
- bit_count  output  $clog2(ShiftWidth+1)  pulses since restart, saturating at ShiftWidth.
- full  output  1  high when bit_count == ShiftWidth.

Behaviour:
- Reset (async, rst=1):
  - counter = InitialDivisor;
  - every shift bit = ResetValue;
  - bit_count = 0;
  - pulse_out = 0, full = 0.
- pulse_out is combinational: high iff enable=1, restart=0, rst=0 and counter==0.
- Counter update per clock, in priority order:
  1. restart=1: counter <= divisor. restart overrides enable.
  2. enable=1 and counter==0: counter <= divisor (pulse cycle).
  3. enable=1 and counter!=0: counter <= counter-1.
  4. enable=0: counter holds.
- Timing consequences:
  - First pulse after a restart loading value D occurs D+1 enabled cycles later.
  - Subsequent pulses are spaced divisor+1 enabled cycles apart.
  - divisor=0 gives a pulse on every enabled cycle.
  - A divisor change mid-count takes effect only at the next reload (pulse or restart).
- Shift register:
  - On a pulse cycle: parallel_out <= {serial_in, parallel_out[ShiftWidth-1:1]}. Shift right, new bit enters the MSB, the LSB is discarded.
  - After ShiftWidth pulses, the first sampled bit sits at bit 0.
  - Not affected by restart; holds when there is no pulse.
- bit_count:
  - Cleared by restart.
  - Increments on each pulse, saturates at ShiftWidth; further pulses still shift.
- full is combinational from bit_count.
- Reset asserted mid-operation aborts immediately. After release the counter restarts from InitialDivisor, regardless of divisor.
- All state registers update only on rising clk edges, or asynchronously on rst.

Test Plan:
- Reset: assert rst with InitialDivisor=255, ResetValue=1 -> parallel_out=8'hFF, bit_count=0, pulse_out=0; release, enable=1, divisor=3 -> first pulse after 256 cycles, then every 4 cycles.
- Half-bit alignment: restart with divisor=4 for one cycle, then divisor=7 with enable=1 -> pulses at 5, 13, 21 cycles after restart.
- Capture: divisor=0, enable=1, serial_in sequence 1,0,1,1,0,0,1,0 on successive cycles -> after 8 pulses parallel_out=8'h4D, full=1, bit_count=8; a ninth pulse with serial_in=1 -> parallel_out=8'hA6, bit_count stays 8.
- Enable gating: divisor=5, drop enable for 3 cycles mid-count -> pulse delayed by exactly 3 cycles; no shift while enable=0.
- Restart priority: restart=1 coinciding with counter==0 and enable=1 -> pulse_out=0, no shift, counter=divisor, bit_count=0.
- Async reset mid-run: assert rst between clock edges after 5 captured bits -> outputs return to reset values immediately, without waiting for a clock edge.
